// File: rtl/mem_ctrl_if.sv
// Request/RAM bundle for mem_ctrl: fetch port, load/store port and byte RAM.
// Handshake: a requester raises *_req with stable operands, holds it until its
// *_done pulse and drops it in that cycle; *_stall = *_req & ~*_done.
// ram_din carries the byte addressed by ram_a one cycle earlier.
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_data;
    logic              if_done;
    logic              if_stall;

    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_len;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_done;
    logic              mem_stall;

    logic [ADDR_W-1:0] ram_a;
    logic [7:0]        ram_dout;
    logic              ram_wr;
    logic [7:0]        ram_din;

    // slave = the controller; master = requesters plus the RAM
    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
        output if_data, if_done, if_stall, mem_rdata, mem_done, mem_stall,
               ram_a, ram_dout, ram_wr
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
        input  if_data, if_done, if_stall, mem_rdata, mem_done, mem_stall,
               ram_a, ram_dout, ram_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates an instruction-fetch port and a load/store port onto one
// byte-wide synchronous RAM, serialising each access little-endian.
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    mem_ctrl_if.slave  bus,
    output logic [2:0] dbg_state
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IF_RD  = 3'd1,
        MEM_RD = 3'd2,
        MEM_WR = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] addr_k;
    logic [31:0]       wdata;
    logic [31:0]       rd_buf;
    logic [31:0]       rd_next;
    logic [2:0]        cnt;
    logic [2:0]        n;
    logic [2:0]        n_mem;
    logic [1:0]        rd_idx;
    logic              is_mem;
    logic              last_rd;
    logic              last_wr;

    always_comb begin
        case (bus.mem_len)
            2'd0:    n_mem = 3'd1;
            2'd1:    n_mem = 3'd2;
            default: n_mem = 3'd4;
        endcase
    end

    assign addr_k  = base + ADDR_W'(cnt);
    assign last_rd = (cnt == n);
    assign last_wr = (cnt == n - 3'd1);
    // Reads trail the address by one cycle, so the byte arriving now is cnt-1.
    assign rd_idx  = cnt[1:0] - 2'd1;
    assign rd_next = rd_buf | ({24'h0, bus.ram_din} << {rd_idx, 3'b000});

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.mem_req)     state_nx = bus.mem_we ? MEM_WR : MEM_RD;
                else if (bus.if_req) state_nx = IF_RD;
            end
            IF_RD, MEM_RD: if (last_rd) state_nx = DONE;
            MEM_WR:        if (last_wr) state_nx = DONE;
            DONE:          state_nx = IDLE;
            default:       state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.ram_a    = '0;
        bus.ram_dout = 8'h00;
        bus.ram_wr   = 1'b0;
        case (state)
            IF_RD, MEM_RD: if (!last_rd) bus.ram_a = addr_k;
            MEM_WR: begin
                bus.ram_a    = addr_k;
                bus.ram_dout = wdata[{cnt[1:0], 3'b000} +: 8];
                bus.ram_wr   = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.if_done   = (state == DONE) && !is_mem;
    assign bus.mem_done  = (state == DONE) && is_mem;
    assign bus.if_stall  = bus.if_req & ~bus.if_done;
    assign bus.mem_stall = bus.mem_req & ~bus.mem_done;
    assign dbg_state     = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= 3'd0;
            n             <= 3'd0;
            base          <= '0;
            wdata         <= 32'h0;
            rd_buf        <= 32'h0;
            is_mem        <= 1'b0;
            bus.if_data   <= 32'h0;
            bus.mem_rdata <= 32'h0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    cnt    <= 3'd0;
                    rd_buf <= 32'h0;
                    if (bus.mem_req) begin
                        is_mem <= 1'b1;
                        base   <= bus.mem_addr;
                        n      <= n_mem;
                        wdata  <= bus.mem_wdata;
                    end else if (bus.if_req) begin
                        is_mem <= 1'b0;
                        base   <= bus.if_addr;
                        n      <= 3'd4;
                    end
                end
                IF_RD, MEM_RD: begin
                    cnt <= cnt + 3'd1;
                    if (cnt != 3'd0) begin
                        rd_buf <= rd_next;
                        // Port data only changes when a read on that port completes.
                        if (last_rd) begin
                            if (is_mem) bus.mem_rdata <= rd_next;
                            else        bus.if_data   <= rd_next;
                        end
                    end
                end
                MEM_WR:  cnt <= cnt + 3'd1;
                default: cnt <= 3'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed fetch/load/store/reset scenarios
// against a byte RAM model with one-cycle read latency.
module tb_mem_ctrl;
    localparam int ADDR_W = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] ram [0:65535];
    always @(posedge clk) begin
        if (bus.ram_wr) ram[bus.ram_a[15:0]] <= bus.ram_dout;
        bus.ram_din <= ram[bus.ram_a[15:0]];
    end

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [7:0]  d;
        logic        wr;
    } probe_t;

    probe_t      pr_q[$];
    logic [31:0] if_exp_q[$];
    int          if_cyc_q[$];
    logic [31:0] mem_exp_q[$];
    int          mem_cyc_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_read(input int t0, input logic [31:0] base, input int n,
                            input logic is_mem, input logic [31:0] data);
        for (int k = 0; k < n; k++) pr_q.push_back('{t0 + k + 1, base + 32'(k), 8'h00, 1'b0});
        pr_q.push_back('{t0 + n + 2, 32'h0, 8'h00, 1'b0});
        if (is_mem) begin
            mem_exp_q.push_back(data);
            mem_cyc_q.push_back(t0 + n + 2);
        end else begin
            if_exp_q.push_back(data);
            if_cyc_q.push_back(t0 + n + 2);
        end
    endtask

    task automatic exp_write(input int t0, input logic [31:0] base, input int n,
                             input logic [31:0] wdata, input logic [31:0] held_rdata);
        logic [31:0] w;
        w = wdata;
        for (int k = 0; k < n; k++) pr_q.push_back('{t0 + k + 1, base + 32'(k), w[8*k +: 8], 1'b1});
        pr_q.push_back('{t0 + n + 1, 32'h0, 8'h00, 1'b0});
        mem_exp_q.push_back(held_rdata);
        mem_cyc_q.push_back(t0 + n + 1);
    endtask

    task automatic wait_done(input logic is_mem);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            seen = is_mem ? bus.mem_done : bus.if_done;
            if (seen) break;
        end
        check(is_mem ? "mem_done_timeout" : "if_done_timeout", 32'(seen), 32'h1);
        #1;
        if (is_mem) bus.mem_req = 1'b0;
        else        bus.if_req  = 1'b0;
    endtask

    // Monitor: RAM-side probes by cycle, done pulses popped from the queues.
    always @(negedge clk) begin
        if (mon_en) begin
            while (pr_q.size() > 0 && pr_q[0].cyc <= cyc) begin
                probe_t p;
                p = pr_q.pop_front();
                check("probe_cycle", 32'(cyc), 32'(p.cyc));
                check("ram_a", bus.ram_a, p.a);
                check("ram_wr", 32'(bus.ram_wr), 32'(p.wr));
                if (p.wr) check("ram_dout", 32'(bus.ram_dout), 32'(p.d));
            end
            if (bus.if_done) begin
                if (if_exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL if_done_unexpected: got if_done=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    check("if_data", bus.if_data, if_exp_q.pop_front());
                    check("if_done_cycle", 32'(cyc), 32'(if_cyc_q.pop_front()));
                end
            end
            if (bus.mem_done) begin
                if (mem_exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL mem_done_unexpected: got mem_done=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    check("mem_rdata", bus.mem_rdata, mem_exp_q.pop_front());
                    check("mem_done_cycle", 32'(cyc), 32'(mem_cyc_q.pop_front()));
                end
            end
            if (bus.if_req)  check("if_stall", 32'(bus.if_stall), 32'(!bus.if_done));
            if (bus.mem_req) check("mem_stall", 32'(bus.mem_stall), 32'(!bus.mem_done));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        bus.if_req    = 1'b0;
        bus.if_addr   = 32'h0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_len   = 2'd0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05; ram[16'h0102] = 8'h10; ram[16'h0103] = 8'h00;
        ram[16'h0104] = 8'h13; ram[16'h0105] = 8'h01; ram[16'h0106] = 8'h01; ram[16'h0107] = 8'hFF;
        ram[16'h2000] = 8'hF0;
        ram[16'hFFFF] = 8'h34; ram[16'h0000] = 8'h12;
        ram[16'h0200] = 8'hAA; ram[16'h0201] = 8'hBB; ram[16'h0202] = 8'hCC; ram[16'h0203] = 8'hDD;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_if_data", bus.if_data, 32'h0);
        check("rst_mem_rdata", bus.mem_rdata, 32'h0);
        check("rst_if_done", 32'(bus.if_done), 32'h0);
        check("rst_mem_done", 32'(bus.mem_done), 32'h0);
        check("rst_ram_a", bus.ram_a, 32'h0);
        check("rst_ram_dout", 32'(bus.ram_dout), 32'h0);
        check("rst_ram_wr", 32'(bus.ram_wr), 32'h0);
        check("rst_state", 32'(dbg_state), 32'h0);
        #1 rst = 1'b1;
        @(negedge clk);
        #1 mon_en = 1'b1;

        // Fetch at 0x100: bytes 13 05 10 00, done in cycle 6
        @(negedge clk); #1;
        t0 = cyc;
        exp_read(t0, 32'h100, 4, 1'b0, 32'h00100513);
        bus.if_addr = 32'h100;
        bus.if_req  = 1'b1;
        wait_done(1'b0);

        // Simultaneous: byte load at 0x2000 wins, fetch at 0x104 starts in cycle 4
        @(negedge clk); #1;
        t0 = cyc;
        exp_read(t0, 32'h2000, 1, 1'b1, 32'h000000F0);
        exp_read(t0 + 4, 32'h104, 4, 1'b0, 32'hFF010113);
        bus.mem_addr = 32'h2000;
        bus.mem_len  = 2'd0;
        bus.mem_we   = 1'b0;
        bus.mem_req  = 1'b1;
        bus.if_addr  = 32'h104;
        bus.if_req   = 1'b1;
        fork
            wait_done(1'b1);
            wait_done(1'b0);
        join

        // Store word 0xDEADBEEF at 0x40; mem_rdata keeps the previous load value
        @(negedge clk); #1;
        t0 = cyc;
        exp_write(t0, 32'h40, 4, 32'hDEADBEEF, 32'h000000F0);
        bus.mem_addr  = 32'h40;
        bus.mem_len   = 2'd2;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = 32'hDEADBEEF;
        bus.mem_req   = 1'b1;
        wait_done(1'b1);

        // Word load back with mem_len=3 (treated as word)
        @(negedge clk); #1;
        t0 = cyc;
        exp_read(t0, 32'h40, 4, 1'b1, 32'hDEADBEEF);
        bus.mem_addr = 32'h40;
        bus.mem_len  = 2'd3;
        bus.mem_we   = 1'b0;
        bus.mem_req  = 1'b1;
        wait_done(1'b1);

        // Half load at 0xFFFFFFFF wraps to 0x00000000, upper half zero
        @(negedge clk); #1;
        t0 = cyc;
        exp_read(t0, 32'hFFFFFFFF, 2, 1'b1, 32'h00001234);
        bus.mem_addr = 32'hFFFFFFFF;
        bus.mem_len  = 2'd1;
        bus.mem_req  = 1'b1;
        wait_done(1'b1);

        // Byte load of 0xBE: zero-extended, no sign extension
        @(negedge clk); #1;
        t0 = cyc;
        exp_read(t0, 32'h41, 1, 1'b1, 32'h000000BE);
        bus.mem_addr = 32'h41;
        bus.mem_len  = 2'd0;
        bus.mem_req  = 1'b1;
        wait_done(1'b1);

        // Reset in cycle 3 of a fetch: outputs clear at once, no done pulse
        @(negedge clk); #1;
        t0 = cyc;
        for (int k = 0; k < 3; k++) pr_q.push_back('{t0 + k + 1, 32'h200 + 32'(k), 8'h00, 1'b0});
        bus.if_addr = 32'h200;
        bus.if_req  = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort_ram_a", bus.ram_a, 32'h0);
        check("abort_ram_wr", 32'(bus.ram_wr), 32'h0);
        check("abort_if_done", 32'(bus.if_done), 32'h0);
        check("abort_if_data", bus.if_data, 32'h0);
        check("abort_mem_rdata", bus.mem_rdata, 32'h0);
        check("abort_state", 32'(dbg_state), 32'h0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        t0 = cyc;
        exp_read(t0, 32'h200, 4, 1'b0, 32'hDDCCBBAA);
        wait_done(1'b0);

        repeat (4) @(negedge clk);
        check("if_queue_empty", 32'(if_exp_q.size()), 32'h0);
        check("mem_queue_empty", 32'(mem_exp_q.size()), 32'h0);
        check("probe_queue_empty", 32'(pr_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width of all address ports.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-004 SHALL have ports if_req input 1 fetch request; if_addr input ADDR_W fetch address; if_data output 32 fetched word; if_done output 1 fetch complete pulse; if_stall output 1 fetch pending.
REQ-005 SHALL have ports mem_req input 1 load/store request; mem_we input 1 (1 = store); mem_len input 2 (0 byte, 1 half, 2/3 word); mem_addr input ADDR_W; mem_wdata input 32; mem_rdata output 32; mem_done output 1; mem_stall output 1.
REQ-006 SHALL have ports ram_a output ADDR_W byte address; ram_dout output 8 write byte; ram_wr output 1 (1 = write); ram_din input 8 read byte.

Function
REQ-007 SHALL arbitrate the IF and MEM ports onto a single byte-wide RAM, one transaction at a time.
REQ-008 SHALL implement states IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
REQ-009 SHALL, in IDLE with mem_req=1, go to MEM_WR if mem_we=1, else MEM_RD; else with if_req=1 go to IF_RD; simultaneous requests: MEM wins, IF waits.
REQ-010 SHALL latch address, len, we and wdata at acceptance; request inputs changing mid-transaction are ignored.
REQ-011 SHALL set byte count n = 4 for IF; n = 1/2/4 for mem_len 0/1/2, mem_len=3 treated as 2.
REQ-012 SHALL emit byte addresses base+k, k=0..n-1, little-endian; addition wraps modulo 2^ADDR_W.
REQ-013 SHALL treat RAM read latency as one cycle: ram_din in cycle t+1 is the byte at ram_a of cycle t.
REQ-014 SHALL, cycle 0 being the IDLE cycle sampling the request: read drives ram_a=base+k in cycle k+1, captures ram_din into bits [8k+7:8k] at end of cycle k+2, enters DONE in cycle n+2.
REQ-015 SHALL, for writes, drive ram_a=base+k, ram_dout=wdata[8k+7:8k], ram_wr=1 in cycle k+1, entering DONE in cycle n+1.
REQ-016 SHALL zero unread upper bytes of mem_rdata; no sign extension.
REQ-017 SHALL, in DONE, pulse if_done or mem_done (owning port only) for exactly one cycle with if_data/mem_rdata valid, then return to IDLE; IDLE may accept a new request next cycle.
REQ-018 SHALL hold if_data and mem_rdata stable until the next completed read on that port.
REQ-019 SHALL drive if_stall = if_req & ~if_done and mem_stall = mem_req & ~mem_done combinationally.
REQ-020 SHALL drive ram_wr=0 in every state except MEM_WR, and ram_a=0, ram_dout=0 in IDLE and DONE.
REQ-021 SHALL require requesters to hold req until their done pulse and deassert it in the done cycle; req high in DONE is not accepted.

Reset
REQ-022 SHALL, while rst=0, force state IDLE, counters 0, and ram_a, ram_dout, ram_wr, if_data, mem_rdata, if_done, mem_done to 0.
REQ-023 SHALL abort any in-flight transaction on reset with no done pulse; after release, a held request is accepted at the first IDLE cycle.

Verification
REQ-024 SHALL cover IF fetch if_addr=0x100, RAM bytes 0x13,0x05,0x10,0x00 -> ram_a 0x100..0x103 in cycles 1..4, if_done in cycle 6, if_data=0x00100513.
REQ-025 SHALL cover simultaneous if_req and mem_req load byte at 0x2000 (0xF0) -> MEM served first, mem_rdata=0x000000F0, mem_done cycle 3, IF starts after, if_stall high throughout.
REQ-026 SHALL cover store word 0xDEADBEEF at 0x40 -> ram_wr=1 cycles 1..4, ram_dout EF,BE,AD,DE at 0x40..0x43, mem_done cycle 5.
REQ-027 SHALL cover half load at 0xFFFFFFFF -> ram_a 0xFFFFFFFF then 0x00000000, upper 16 bits of mem_rdata zero.
REQ-028 SHALL cover rst=0 in cycle 3 of IF fetch -> outputs 0 immediately, no if_done; after release, fetch restarts at cycle-0 timing.
